// File: rtl/axis_if.sv
// AXI4-Stream bundle shared by the sink and source sides of the stream buffer.
// A beat moves on a rising clk edge where tvalid and tready are both high. The source
// holds tvalid and every payload field stable until that edge, and tvalid never depends
// on tready. The sink may raise or lower tready freely.
interface axis_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_register_fifo.sv
// DEPTH-entry flop-based AXI4-Stream buffer with registered s_axis tready, occupancy
// count, synchronous flush and optional store-and-forward release of whole frames.
module axis_register_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 4,
    parameter int FRAME_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    axis_if.slave                  s_axis,
    axis_if.master                 m_axis,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Frame gating needs tlast; without it the buffer always runs cut-through.
    localparam bit FRAMED = (FRAME_MODE != 0) && (LAST_ENABLE != 0);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
    logic                  mem_last [DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [DEPTH];
    logic [USER_WIDTH-1:0] mem_user [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] out_idx;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_next;
    logic             pass;
    logic             s_ready;
    logic             m_valid;
    logic             acc;
    logic             pop;
    logic             in_last;
    logic             head_last;

    assign acc       = s_axis.tvalid & s_ready;
    assign pop       = m_valid & m_axis.tready;
    assign in_last   = (LAST_ENABLE != 0) & s_axis.tlast;
    assign head_last = mem_last[rd_ptr];

    assign count_next     = count + CNT_W'(acc) - CNT_W'(pop);
    assign frame_cnt_next = frame_cnt + CNT_W'(acc & in_last) - CNT_W'(pop & head_last);

    // pass lets an oversize frame stream out once it fills the buffer, avoiding deadlock.
    assign m_valid = (count != '0) && (!FRAMED || (frame_cnt != '0) || pass);

    // While empty, show the most recently popped entry so the payload holds its last value.
    assign out_idx = (count != '0) ? rd_ptr : rd_ptr - PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            pass      <= 1'b0;
            s_ready   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_keep[i] <= '0;
                mem_last[i] <= 1'b0;
                mem_id[i]   <= '0;
                mem_dest[i] <= '0;
                mem_user[i] <= '0;
            end
        end else if (flush) begin
            // Control clears exactly like reset; stored payload is left untouched.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            pass      <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            if (acc) begin
                mem_data[wr_ptr] <= s_axis.tdata;
                mem_keep[wr_ptr] <= s_axis.tkeep;
                mem_last[wr_ptr] <= s_axis.tlast;
                mem_id[wr_ptr]   <= s_axis.tid;
                mem_dest[wr_ptr] <= s_axis.tdest;
                mem_user[wr_ptr] <= s_axis.tuser;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            s_ready <= (count_next < CNT_W'(DEPTH));
            if (FRAMED) begin
                frame_cnt <= frame_cnt_next;
                if (pop && head_last) begin
                    pass <= 1'b0;
                end else if ((count == CNT_W'(DEPTH)) && (frame_cnt == '0)) begin
                    pass <= 1'b1;
                end
            end
        end
    end

    assign s_axis.tready = s_ready;

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = mem_data[out_idx];
    assign m_axis.tkeep  = (KEEP_ENABLE != 0) ? mem_keep[out_idx] : '1;
    assign m_axis.tlast  = (LAST_ENABLE != 0) ? mem_last[out_idx] : 1'b1;
    assign m_axis.tid    = (ID_ENABLE != 0)   ? mem_id[out_idx]   : '0;
    assign m_axis.tdest  = (DEST_ENABLE != 0) ? mem_dest[out_idx] : '0;
    assign m_axis.tuser  = (USER_ENABLE != 0) ? mem_user[out_idx] : '0;
endmodule

// File: tb/tb_axis_register_fifo.sv
// Bench for axis_register_fifo: a cut-through instance (a) and a frame-mode instance (b),
// both DEPTH=4, checked through per-instance expected-beat queues plus timing probes.
module tb_axis_register_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush_a;
    logic       flush_b;
    logic [2:0] count_a;
    logic [2:0] count_b;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_fq[$];

    always #5 clk = ~clk;

    axis_if sa ();
    axis_if ma ();
    axis_if sb ();
    axis_if mb ();

    axis_register_fifo #(.DEPTH(4), .FRAME_MODE(0)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_a),
        .s_axis (sa),
        .m_axis (ma),
        .count  (count_a)
    );

    axis_register_fifo #(.DEPTH(4), .FRAME_MODE(1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_b),
        .s_axis (sb),
        .m_axis (mb),
        .count  (count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: accepted beats are queued, popped beats are compared in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush_a) begin
                exp_q.delete();
            end else begin
                if (ma.tvalid && ma.tready) begin
                    if (exp_q.size() == 0) check("a_sb_extra_beat", 1, 0);
                    else check("a_beat", {ma.tlast, ma.tuser, ma.tdata}, exp_q.pop_front());
                end
                if (sa.tvalid && sa.tready) exp_q.push_back({sa.tlast, sa.tuser, sa.tdata});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mb.tvalid && mb.tready) begin
                if (exp_fq.size() == 0) check("b_sb_extra_beat", 1, 0);
                else check("b_beat", {mb.tlast, mb.tuser, mb.tdata}, exp_fq.pop_front());
            end
            if (sb.tvalid && sb.tready) exp_fq.push_back({sb.tlast, sb.tuser, sb.tdata});
        end
    end

    // Call at posedge+1; returns at posedge+1 right after the beat was accepted.
    task automatic send(input bit sel, input logic [7:0] d, input logic last);
        int n;
        n = 0;
        if (sel) begin
            sb.tvalid = 1'b1; sb.tdata = d; sb.tlast = last; sb.tuser = ~d[0];
        end else begin
            sa.tvalid = 1'b1; sa.tdata = d; sa.tlast = last; sa.tuser = ~d[0];
        end
        @(negedge clk);
        while (!(sel ? sb.tready : sa.tready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n >= 100), 0);
        @(posedge clk);
        #1;
        if (sel) begin
            sb.tvalid = 1'b0; sb.tlast = 1'b0;
        end else begin
            sa.tvalid = 1'b0; sa.tlast = 1'b0;
        end
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while ((sel ? count_b : count_a) != 3'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "drain_b" : "drain_a", sel ? count_b : count_a, 0);
        check(sel ? "sb_left_b" : "sb_left_a", sel ? exp_fq.size() : exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        sa.tvalid = 1'b0; sa.tdata = '0; sa.tkeep = '1; sa.tlast = 1'b0;
        sa.tid = '0; sa.tdest = '0; sa.tuser = '0;
        sb.tvalid = 1'b0; sb.tdata = '0; sb.tkeep = '1; sb.tlast = 1'b0;
        sb.tid = '0; sb.tdest = '0; sb.tuser = '0;
        ma.tready = 1'b0;
        mb.tready = 1'b0;

        // Reset / idle
        repeat (3) begin
            @(negedge clk);
            check("rst_tready_a", sa.tready, 0);
            check("rst_tready_b", sb.tready, 0);
            check("rst_tvalid_a", ma.tvalid, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rel_tready_lag", sa.tready, 0);
        @(negedge clk);
        check("idle_tready_a", sa.tready, 1);
        check("idle_tready_b", sb.tready, 1);
        check("idle_tvalid_a", ma.tvalid, 0);
        check("idle_tvalid_b", mb.tvalid, 0);
        check("idle_count_a", count_a, 0);
        check("idle_tdata_a", ma.tdata, 0);
        check("idle_tkeep_a", ma.tkeep, 1);
        check("idle_tid_a", ma.tid, 0);

        // Streaming at one beat per cycle
        @(posedge clk); #1 ma.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sa.tvalid = 1'b1; sa.tdata = 8'(i); sa.tuser = ~sa.tdata[0]; sa.tlast = (i == 15);
            @(negedge clk);
            check("stream_valid", ma.tvalid, 32'(i != 0));
            check("stream_count", count_a, 32'(i != 0));
            check("stream_tready", sa.tready, 1);
            if (i != 0) check("stream_data", ma.tdata, 32'(i - 1));
            @(posedge clk); #1;
        end
        sa.tvalid = 1'b0; sa.tlast = 1'b0;
        @(negedge clk);
        check("stream_tail_valid", ma.tvalid, 1);
        check("stream_tail_data", ma.tdata, 8'h0F);
        @(negedge clk);
        check("stream_end_valid", ma.tvalid, 0);
        check("stream_end_count", count_a, 0);

        // Fill and backpressure
        @(posedge clk); #1 ma.tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send(1'b0, 8'(8'h10 + k), k == 5);
            end
            begin
                repeat (5) @(negedge clk);
                check("fill_count", count_a, 4);
                check("fill_tready", sa.tready, 0);
                check("fill_valid", ma.tvalid, 1);
                check("fill_data", ma.tdata, 8'h10);
                repeat (3) @(negedge clk);
                check("fill_hold_count", count_a, 4);
                check("fill_hold_tready", sa.tready, 0);
                check("fill_hold_data", ma.tdata, 8'h10);
                @(posedge clk); #1 ma.tready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("unfull_count", count_a, 3);
                check("unfull_tready", sa.tready, 1);
            end
        join
        drain(1'b0);

        // Flush with three beats held and one beat offered during the flush
        @(posedge clk); #1 ma.tready = 1'b0;
        send(1'b0, 8'h31, 1'b0);
        send(1'b0, 8'h32, 1'b0);
        send(1'b0, 8'h33, 1'b0);
        flush_a = 1'b1; sa.tvalid = 1'b1; sa.tdata = 8'h77; sa.tuser = 1'b0;
        @(negedge clk);
        check("pre_flush_count", count_a, 3);
        @(posedge clk); #1;
        flush_a = 1'b0; sa.tvalid = 1'b0;
        check("flush_count", count_a, 0);
        check("flush_valid", ma.tvalid, 0);
        check("flush_tready", sa.tready, 0);
        @(posedge clk); #1;
        check("post_flush_tready", sa.tready, 1);
        check("post_flush_count", count_a, 0);
        ma.tready = 1'b1;
        send(1'b0, 8'hA5, 1'b1);
        check("flush_next_valid", ma.tvalid, 1);
        check("flush_next_data", ma.tdata, 8'hA5);
        drain(1'b0);

        // Frame mode: 3-beat frame with a gap before tlast
        @(posedge clk); #1 mb.tready = 1'b1;
        send(1'b1, 8'h41, 1'b0);
        check("frm_hold0", mb.tvalid, 0);
        send(1'b1, 8'h42, 1'b0);
        check("frm_hold1", mb.tvalid, 0);
        check("frm_count2", count_b, 2);
        @(posedge clk); #1;
        check("frm_gap", mb.tvalid, 0);
        send(1'b1, 8'h43, 1'b1);
        check("frm_rel_valid", mb.tvalid, 1);
        check("frm_rel_count", count_b, 3);
        check("frm_rel_data0", mb.tdata, 8'h41);
        @(posedge clk); #1;
        check("frm_b2b_valid1", mb.tvalid, 1);
        check("frm_b2b_data1", mb.tdata, 8'h42);
        @(posedge clk); #1;
        check("frm_b2b_valid2", mb.tvalid, 1);
        check("frm_b2b_data2", mb.tdata, 8'h43);
        check("frm_b2b_last", mb.tlast, 1);
        @(posedge clk); #1;
        check("frm_done_valid", mb.tvalid, 0);
        check("frm_done_count", count_b, 0);

        // Oversize frame: 7 beats through a 4-entry buffer
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 7; k++) send(1'b1, 8'(8'h60 + k), k == 6);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (count_b != 3'd4 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("ovs_full", count_b, 4);
                check("ovs_wait_valid", mb.tvalid, 0);
                check("ovs_full_tready", sb.tready, 0);
                @(negedge clk);
                check("ovs_pass_valid", mb.tvalid, 1);
                check("ovs_pass_data", mb.tdata, 8'h60);
            end
        join
        drain(1'b1);
        check("ovs_end_valid", mb.tvalid, 0);

        // After the oversize frame, an unterminated beat must be held again
        @(posedge clk); #1;
        send(1'b1, 8'h70, 1'b0);
        check("pass_clr_valid0", mb.tvalid, 0);
        @(posedge clk); #1;
        check("pass_clr_valid1", mb.tvalid, 0);
        send(1'b1, 8'h71, 1'b1);
        check("pass_clr_rel_valid", mb.tvalid, 1);
        check("pass_clr_rel_data", mb.tdata, 8'h70);
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
